// File: rtl/uart_pkg.sv
// uart_pkg: shared state encoding, default byte width and width helper
// for the UART TX arbiter and its selector.
package uart_pkg;
    typedef enum logic [1:0] {IDLE, LAUNCH, WAIT_BUSY, WAIT_DONE} state_t;
    localparam int DATA_W_DEF = 8;
    function automatic int clog2(input int v);
        int r = 1;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: requester handshake and transmitter-side signals.
// master drives requests and transmitter status; slave is the arbiter.
interface uart_tx_arbiter_if import uart_pkg::*; #(
    parameter int N_REQ  = 4,
    parameter int DATA_W = DATA_W_DEF
);
    logic [N_REQ-1:0]        req_valid;
    logic [N_REQ-1:0]        req_ready;
    logic [N_REQ*DATA_W-1:0] req_data;
    logic [DATA_W-1:0]       tx_byte;
    logic [clog2(N_REQ)-1:0] grant_id;
    logic                    tx_start;
    logic                    tx_busy;
    logic                    tx_done;
    logic                    timeout_err;
    logic                    active;
    modport master (
        output req_valid, req_data, tx_busy, tx_done,
        input  req_ready, tx_start, tx_byte, grant_id, timeout_err, active
    );
    modport slave (
        input  req_valid, req_data, tx_busy, tx_done,
        output req_ready, tx_start, tx_byte, grant_id, timeout_err, active
    );
endinterface

// File: rtl/uart_tx_arbiter_rr_select.sv
// rr_select: rotate-priority search returning the first set request at or
// after ptr, wrapping at N-1.
module rr_select import uart_pkg::*; #(
    parameter int N = 4,
    parameter int W = clog2(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         any_valid
);
    logic [W-1:0] idx;
    // scan farthest to nearest so the nearest hit is written last
    always_comb begin
        sel = '0;
        idx = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = W'((int'(ptr) + i) % N);
            if (req[idx]) sel = idx;
        end
    end
    assign any_valid = |req;
endmodule

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between N_REQ requesters with
// round-robin grants, burst lock and a completion watchdog.
module uart_tx_arbiter import uart_pkg::*; #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = DATA_W_DEF,
    parameter int MAX_BURST = 4,
    parameter int TIMEOUT   = 4095
) (
    input logic              clk_tx,
    input logic              reset_n,
    uart_tx_arbiter_if.slave bus
);
    localparam int IW = clog2(N_REQ);
    localparam int BW = clog2(MAX_BURST + 1);
    localparam int WW = clog2(TIMEOUT + 1);

    state_t        state;
    logic [IW-1:0] rr_ptr;
    logic [IW-1:0] sel;
    logic [IW-1:0] next_ptr;
    logic [BW-1:0] burst_cnt;
    logic [WW-1:0] wd_cnt;
    logic          any_valid;
    logic          waiting;
    logic          again;
    logic          expire;

    rr_select #(.N(N_REQ), .W(IW)) u_sel (
        .req(bus.req_valid), .ptr(rr_ptr), .sel(sel), .any_valid(any_valid)
    );

    assign waiting  = state == WAIT_BUSY || state == WAIT_DONE;
    assign again    = bus.req_valid[bus.grant_id] && burst_cnt < BW'(MAX_BURST);
    assign next_ptr = bus.grant_id == IW'(N_REQ - 1) ? '0 : bus.grant_id + IW'(1);
    // LAUNCH and the expiry edge itself supply the last two of the TIMEOUT cycles
    assign expire   = wd_cnt == WW'(TIMEOUT - 2);
    assign bus.req_ready = !reset_n ? '0 :
                           state == IDLE && any_valid ? N_REQ'(1) << sel :
                           waiting && bus.tx_done && again ? N_REQ'(1) << bus.grant_id : '0;

    always_ff @(posedge clk_tx or negedge reset_n)
        if (!reset_n) begin
            state           <= IDLE;
            rr_ptr          <= '0;
            burst_cnt       <= '0;
            wd_cnt          <= '0;
            bus.tx_start    <= 1'b0;
            bus.tx_byte     <= '0;
            bus.grant_id    <= '0;
            bus.timeout_err <= 1'b0;
            bus.active      <= 1'b0;
        end else begin
            bus.tx_start <= 1'b0;
            case (state)
                IDLE: if (any_valid) begin
                    bus.tx_byte  <= bus.req_data[sel*DATA_W +: DATA_W];
                    bus.grant_id <= sel;
                    bus.tx_start <= 1'b1;
                    bus.active   <= 1'b1;
                    burst_cnt    <= BW'(1);
                    state        <= LAUNCH;
                end
                LAUNCH: begin
                    wd_cnt <= '0;
                    state  <= WAIT_BUSY;
                end
                default: begin
                    wd_cnt <= wd_cnt + WW'(1);
                    if (bus.tx_done && again) begin
                        bus.tx_byte  <= bus.req_data[bus.grant_id*DATA_W +: DATA_W];
                        bus.tx_start <= 1'b1;
                        burst_cnt    <= burst_cnt + BW'(1);
                        state        <= LAUNCH;
                    end else if (bus.tx_done || expire) begin
                        if (!bus.tx_done) bus.timeout_err <= 1'b1;
                        rr_ptr     <= next_ptr;
                        bus.active <= 1'b0;
                        state      <= IDLE;
                    end else if (state == WAIT_BUSY && bus.tx_busy)
                        state <= WAIT_DONE;
                end
            endcase
        end
endmodule
